seq_checker: RTL and testbench
==============================

Name: seq_checker

Overview:
- Parametrised successor to the single-step pattern comparator.
- Checks a whole round of player presses against the stored round sequence, one symbol per press, in order.
- Adds a per-press response timeout and a run/abort mode.
- Sits between the debounced button/switch front end and the game-control FSM, and reads expected symbols from the sequence memory.

Parameters:
- W, 4, width of one symbol (button/switch vector).
- MAX_LEN, 16, maximum round length (symbols); must be ≥ 2.
- TIMEOUT_CYC, 50000000, clock cycles allowed between consecutive presses; must be ≥ 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- on_off  input  1  run enable; low aborts any check in progress and forces IDLE.
- start  input  1  one-cycle pulse: begin checking a round.
- seq_len  input  $clog2(MAX_LEN+1)  number of symbols in the round; sampled on start.
- in_valid  input  1  one-cycle pulse per player press.
- sw  input  W  player symbol; valid when in_valid=1.
- rd_addr  output  $clog2(MAX_LEN)  index of the expected symbol (driven from idx).
- rd_data  input  W  expected symbol; combinational read of rd_addr, sampled the same cycle.
- busy  output  1  high while in CHECK.
- idx  output  $clog2(MAX_LEN)  number of symbols matched so far in the current round.
- done  output  1  one-cycle pulse when the round ends (pass or fail).
- pass  output  1  round matched fully; held until the next accepted start or abort.
- fail  output  1  round failed; held like pass.
- fail_code  output  2  0 none, 1 mismatch, 2 timeout, 3 bad length; held like pass.

Behaviour:
- Reset (async assert) values: state=IDLE; busy, done, pass, fail, idx, fail_code, timer all 0.
- All outputs are registered. rd_addr = idx.
- States are IDLE, CHECK and RESULT.
- IDLE:
  - start with on_off=1 and 1 ≤ seq_len ≤ MAX_LEN → CHECK.
  - On that entry: len latched, idx=0, timer=0, pass=fail=0, fail_code=0.
  - start with seq_len=0 or seq_len>MAX_LEN → RESULT with fail=1, fail_code=3, done pulse next cycle.
- CHECK:
  - busy=1; timer increments every cycle in which in_valid=0.
  - in_valid and sw==rd_data and idx==len-1 → RESULT, pass=1, done=1.
  - in_valid and sw==rd_data otherwise → idx+1, timer=0, stay in CHECK.
  - in_valid and sw!=rd_data → RESULT, fail=1, fail_code=1, done=1; idx holds the failing position.
  - No in_valid and timer==TIMEOUT_CYC-1 → RESULT, fail=1, fail_code=2, done=1.
- RESULT:
  - done high exactly one cycle, on the cycle of entry.
  - Then wait in RESULT with pass/fail/fail_code/idx held.
  - start restarts with the same rules as in IDLE.
- Latency: the in_valid cycle at t gives done/pass/fail visible at t+1. A matching press gives idx+1 at t+1.
- Simultaneous events:
  - in_valid and timeout in the same cycle: the press wins; its compare is evaluated and the timer is cleared.
  - start during CHECK: restart takes priority over any in_valid that cycle. No done pulse for the aborted round.
  - on_off low: takes priority over everything except reset. Next cycle: IDLE, busy=0, pass=fail=0, fail_code=0, idx=0, no done.
  - in_valid while in IDLE or RESULT is ignored.
- Widths: the timer is $clog2(TIMEOUT_CYC) bits and never wraps (it is bounded by the timeout compare). idx never exceeds MAX_LEN-1.
- Reset asserted mid-round: immediate return to the reset values. No done pulse.

Test Plan:
- W=4, MAX_LEN=16, TIMEOUT_CYC=20; memory holds 1,2,4,8. start with seq_len=4; press 1,2,4,8 at 3-cycle spacing → idx steps 1,2,3; done pulses 1 cycle after the 4th press; pass=1, fail_code=0.
- Same sequence, presses 1,2,8 → done 1 cycle after the 3rd press; fail=1, fail_code=1, idx=2; a later press in RESULT changes nothing.
- seq_len=4, press 1, then 20 idle cycles → done on the cycle after timer reaches 19; fail_code=2, idx=1. In a separate run, a press in the exact timeout cycle is evaluated as a normal press.
- start with seq_len=0 → fail_code=3, done 1 cycle later. start with seq_len=17 → fail_code=3.
- Mid-round: drop on_off after 2 matches → IDLE next cycle, all outputs 0, no done. Repeat the round and assert start after 2 matches → idx=0, busy=1, no done.
- Assert reset asynchronously (between clock edges) during CHECK → outputs 0 before the next edge. After release, a full 4-symbol round passes.

Source files
------------

// File: rtl/seq_checker.sv
// Round sequence checker: compares each player press against the stored
// round sequence, with per-press timeout and run/abort control.
module seq_checker #(
   parameter int W           = 4,
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         on_off,
   input  logic                         start,
   input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
   input  logic                         in_valid,
   input  logic [W-1:0]                 sw,
   output logic [$clog2(MAX_LEN)-1:0]   rd_addr,
   input  logic [W-1:0]                 rd_data,
   output logic                         busy,
   output logic [$clog2(MAX_LEN)-1:0]   idx,
   output logic                         done,
   output logic                         pass,
   output logic                         fail,
   output logic [1:0]                   fail_code
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int TMR_W = $clog2(TIMEOUT_CYC);

   localparam logic [1:0] CODE_NONE = 2'd0;
   localparam logic [1:0] CODE_MISM = 2'd1;
   localparam logic [1:0] CODE_TOUT = 2'd2;
   localparam logic [1:0] CODE_BLEN = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      RESULT
   } state_t;

   state_t             state, state_n;
   logic [LEN_W-1:0]   len, len_n;
   logic [IDX_W-1:0]   idx_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic               busy_n, done_n, pass_n, fail_n;
   logic [1:0]         code_n;
   logic               len_ok;
   logic               last_sym;
   logic               tout;

   assign rd_addr  = idx;
   assign len_ok   = (seq_len != '0) && (seq_len <= LEN_W'(MAX_LEN));
   assign last_sym = ((LEN_W'(idx) + LEN_W'(1)) == len);
   assign tout     = (timer == TMR_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         len       <= '0;
         idx       <= '0;
         timer     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= CODE_NONE;
      end else begin
         state     <= state_n;
         len       <= len_n;
         idx       <= idx_n;
         timer     <= timer_n;
         busy      <= busy_n;
         done      <= done_n;
         pass      <= pass_n;
         fail      <= fail_n;
         fail_code <= code_n;
      end
   end

   always_comb begin
      state_n = state;
      len_n   = len;
      idx_n   = idx;
      timer_n = timer;
      done_n  = 1'b0;
      pass_n  = pass;
      fail_n  = fail;
      code_n  = fail_code;

      // Abort beats start, which beats any press in the same cycle
      if (!on_off) begin
         state_n = IDLE;
         idx_n   = '0;
         timer_n = '0;
         pass_n  = 1'b0;
         fail_n  = 1'b0;
         code_n  = CODE_NONE;
      end else if (start) begin
         idx_n   = '0;
         timer_n = '0;
         pass_n  = 1'b0;
         if (len_ok) begin
            state_n = CHECK;
            len_n   = seq_len;
            fail_n  = 1'b0;
            code_n  = CODE_NONE;
         end else begin
            state_n = RESULT;
            done_n  = 1'b1;
            fail_n  = 1'b1;
            code_n  = CODE_BLEN;
         end
      end else if (state == CHECK) begin
         if (in_valid) begin
            timer_n = '0;
            if (sw != rd_data) begin
               state_n = RESULT;
               done_n  = 1'b1;
               fail_n  = 1'b1;
               code_n  = CODE_MISM;
            end else if (last_sym) begin
               state_n = RESULT;
               done_n  = 1'b1;
               pass_n  = 1'b1;
            end else begin
               idx_n = idx + IDX_W'(1);
            end
         end else if (tout) begin
            state_n = RESULT;
            timer_n = '0;
            done_n  = 1'b1;
            fail_n  = 1'b1;
            code_n  = CODE_TOUT;
         end else begin
            timer_n = timer + TMR_W'(1);
         end
      end

      busy_n = (state_n == CHECK);
   end

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: vector table plus hand-written
// timeout, abort and asynchronous-reset sequences.
module tb_seq_checker;

   localparam int W   = 4;
   localparam int ML  = 16;
   localparam int TO  = 20;
   localparam int LW  = $clog2(ML + 1);
   localparam int IW  = $clog2(ML);

   logic          clk = 1'b0;
   logic          reset;
   logic          on_off;
   logic          start;
   logic [LW-1:0] seq_len;
   logic          in_valid;
   logic [W-1:0]  sw;
   logic [IW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          busy;
   logic [IW-1:0] idx;
   logic          done;
   logic          pass;
   logic          fail;
   logic [1:0]    fail_code;

   logic [W-1:0]  mem [ML];

   int checks = 0;
   int errors = 0;

   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   seq_checker #(
      .W           (W),
      .MAX_LEN     (ML),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .on_off    (on_off),
      .start     (start),
      .seq_len   (seq_len),
      .in_valid  (in_valid),
      .sw        (sw),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .idx       (idx),
      .done      (done),
      .pass      (pass),
      .fail      (fail),
      .fail_code (fail_code)
   );

   typedef struct {
      string         nm;
      logic          on;
      logic          st;
      logic [LW-1:0] len;
      logic          iv;
      logic [W-1:0]  s;
      logic          b;
      logic [IW-1:0] i;
      logic          d;
      logic          p;
      logic          f;
      logic [1:0]    c;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(string nm, logic on, logic st,
                               logic [LW-1:0] len, logic iv,
                               logic [W-1:0] s, logic b,
                               logic [IW-1:0] i, logic d, logic p,
                               logic f, logic [1:0] c);
      vec_t v;
      v.nm = nm; v.on = on; v.st = st; v.len = len;
      v.iv = iv; v.s = s; v.b = b; v.i = i;
      v.d = d; v.p = p; v.f = f; v.c = c;
      return v;
   endfunction

   task automatic expect_out(string nm, logic b, logic [IW-1:0] i,
                             logic d, logic p, logic f,
                             logic [1:0] c);
      checks++;
      if ({busy, idx, rd_addr, done, pass, fail, fail_code} !==
          {b, i, i, d, p, f, c}) begin
         errors++;
         $display("FAIL %s: got busy=%0b idx=%0d rd_addr=%0d done=%0b pass=%0b fail=%0b code=%0d, want busy=%0b idx=%0d done=%0b pass=%0b fail=%0b code=%0d",
                  nm, busy, idx, rd_addr, done, pass, fail, fail_code,
                  b, i, d, p, f, c);
      end
   endtask

   task automatic drive(logic on, logic st, logic [LW-1:0] l,
                        logic iv, logic [W-1:0] s);
      on_off   = on;
      start    = st;
      seq_len  = l;
      in_valid = iv;
      sw       = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(logic on, logic st, logic [LW-1:0] l,
                       logic iv, logic [W-1:0] s);
      drive(on, st, l, iv, s);
      tick();
   endtask

   initial begin
      for (int k = 0; k < ML; k++) mem[k] = '0;
      mem[0] = 4'd1;
      mem[1] = 4'd2;
      mem[2] = 4'd4;
      mem[3] = 4'd8;

      // full pass with 3-cycle spacing
      tv.push_back(mk("p_start", 1,1,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("p_w0a",   1,0,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("p_w0b",   1,0,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("p_s1",    1,0,4,1,1, 1,1,0,0,0,0));
      tv.push_back(mk("p_w1a",   1,0,4,0,0, 1,1,0,0,0,0));
      tv.push_back(mk("p_w1b",   1,0,4,0,0, 1,1,0,0,0,0));
      tv.push_back(mk("p_s2",    1,0,4,1,2, 1,2,0,0,0,0));
      tv.push_back(mk("p_w2a",   1,0,4,0,0, 1,2,0,0,0,0));
      tv.push_back(mk("p_w2b",   1,0,4,0,0, 1,2,0,0,0,0));
      tv.push_back(mk("p_s3",    1,0,4,1,4, 1,3,0,0,0,0));
      tv.push_back(mk("p_w3a",   1,0,4,0,0, 1,3,0,0,0,0));
      tv.push_back(mk("p_w3b",   1,0,4,0,0, 1,3,0,0,0,0));
      tv.push_back(mk("p_s4",    1,0,4,1,8, 0,3,1,1,0,0));
      tv.push_back(mk("p_hold",  1,0,4,0,0, 0,3,0,1,0,0));
      // mismatch on third symbol
      tv.push_back(mk("m_start", 1,1,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("m_s1",    1,0,4,1,1, 1,1,0,0,0,0));
      tv.push_back(mk("m_s2",    1,0,4,1,2, 1,2,0,0,0,0));
      tv.push_back(mk("m_bad",   1,0,4,1,8, 0,2,1,0,1,1));
      tv.push_back(mk("m_ignore",1,0,4,1,1, 0,2,0,0,1,1));
      // bad lengths
      tv.push_back(mk("l_zero",  1,1,0,0,0, 0,0,1,0,1,3));
      tv.push_back(mk("l_zhold", 1,0,0,0,0, 0,0,0,0,1,3));
      tv.push_back(mk("l_17",    1,1,17,0,0, 0,0,1,0,1,3));
      tv.push_back(mk("l_17hold",1,0,0,0,0, 0,0,0,0,1,3));
      // abort after two matches
      tv.push_back(mk("a_start", 1,1,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("a_s1",    1,0,4,1,1, 1,1,0,0,0,0));
      tv.push_back(mk("a_s2",    1,0,4,1,2, 1,2,0,0,0,0));
      tv.push_back(mk("a_off",   0,0,4,1,4, 0,0,0,0,0,0));
      tv.push_back(mk("a_idle",  1,0,4,0,0, 0,0,0,0,0,0));
      // restart after two matches, press in same cycle ignored
      tv.push_back(mk("r_start", 1,1,4,0,0, 1,0,0,0,0,0));
      tv.push_back(mk("r_s1",    1,0,4,1,1, 1,1,0,0,0,0));
      tv.push_back(mk("r_s2",    1,0,4,1,2, 1,2,0,0,0,0));
      tv.push_back(mk("r_again", 1,1,4,1,4, 1,0,0,0,0,0));
      tv.push_back(mk("r_s1b",   1,0,4,1,1, 1,1,0,0,0,0));

      reset = 1'b0;
      drive(1, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1 expect_out("reset_async", 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      expect_out("reset_state", 0, 0, 0, 0, 0, 0);

      foreach (tv[n]) begin
         step(tv[n].on, tv[n].st, tv[n].len, tv[n].iv, tv[n].s);
         expect_out(tv[n].nm, tv[n].b, tv[n].i, tv[n].d,
                    tv[n].p, tv[n].f, tv[n].c);
      end

      // timeout after one match
      step(1, 1, 4, 0, 0);
      step(1, 0, 4, 1, 1);
      expect_out("t_s1", 1, 1, 0, 0, 0, 0);
      for (int k = 1; k < TO; k++) begin
         step(1, 0, 4, 0, 0);
         expect_out("t_wait", 1, 1, 0, 0, 0, 0);
      end
      step(1, 0, 4, 0, 0);
      expect_out("t_expire", 0, 1, 1, 0, 1, 2);
      step(1, 0, 4, 0, 0);
      expect_out("t_hold", 0, 1, 0, 0, 1, 2);

      // press landing on the timeout cycle is a normal press
      step(1, 1, 4, 0, 0);
      step(1, 0, 4, 1, 1);
      for (int k = 1; k < TO; k++) step(1, 0, 4, 0, 0);
      expect_out("e_edge", 1, 1, 0, 0, 0, 0);
      step(1, 0, 4, 1, 2);
      expect_out("e_press", 1, 2, 0, 0, 0, 0);
      step(1, 0, 4, 0, 0);
      expect_out("e_cleared", 1, 2, 0, 0, 0, 0);
      step(0, 0, 4, 0, 0);
      expect_out("e_off", 0, 0, 0, 0, 0, 0);

      // asynchronous reset mid-round, then a clean round
      step(1, 1, 4, 0, 0);
      step(1, 0, 4, 1, 1);
      step(1, 0, 4, 1, 2);
      expect_out("x_pre", 1, 2, 0, 0, 0, 0);
      drive(1, 0, 4, 0, 0);
      #2 reset = 1'b1;
      #1 expect_out("x_async", 0, 0, 0, 0, 0, 0);
      tick();
      expect_out("x_held", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step(1, 1, 4, 0, 0);
      expect_out("x_start", 1, 0, 0, 0, 0, 0);
      step(1, 0, 4, 1, 1);
      expect_out("x_s1", 1, 1, 0, 0, 0, 0);
      step(1, 0, 4, 1, 2);
      expect_out("x_s2", 1, 2, 0, 0, 0, 0);
      step(1, 0, 4, 1, 4);
      expect_out("x_s3", 1, 3, 0, 0, 0, 0);
      step(1, 0, 4, 1, 8);
      expect_out("x_pass", 0, 3, 1, 1, 0, 0);
      step(1, 0, 4, 0, 0);
      expect_out("x_hold", 0, 3, 0, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
